fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Small in-order instruction queue between the fetch stage and the decode stage.
- Captures fetched instructions and their PCs, and presents them to decode in order.
- Asserts back-pressure into fetch when full, and discards all contents on a branch redirect.
- Decouples icache-miss bubbles from decode stalls.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2.
INSTR_W, `INSTR_WIDTH, instruction width in bits.
PC_W, `PC_WIDTH, PC width in bits.

Ports:
clock  input  1  core clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  branch redirect (take_branch); discards all entries.
fetch_instr_valid  input  1  fetch presents an instruction this cycle.
fetch_instr_data  input  INSTR_W  fetched instruction.
fetch_instr_pc  input  PC_W  PC of the fetched instruction.
stall_fetch  output  1  queue cannot accept; drives the fetch stage's stall_fetch.
decode_stall  input  1  decode cannot consume this cycle.
decode_instr_valid  output  1  head entry valid.
decode_instr_data  output  INSTR_W  head instruction.
decode_instr_pc  output  PC_W  head PC.
occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- State:
  - Storage array of DEPTH x (INSTR_W+PC_W).
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count, $clog2(DEPTH)+1 bits.
- Reset (asynchronous, immediate):
  - rd_ptr=0, wr_ptr=0, count=0.
  - decode_instr_valid=0, stall_fetch=0, occupancy=0.
  - Storage contents are don't-care and are not reset.
- stall_fetch = (count == DEPTH). It is derived from registered state only; there is no combinational path from any input.
- push = fetch_instr_valid & !stall_fetch & !flush.
  - Writes {data, pc} at wr_ptr; wr_ptr increments.
- pop = decode_instr_valid & !decode_stall & !flush.
  - rd_ptr increments.
- decode_instr_valid = (count != 0).
  - decode_instr_data and decode_instr_pc come from entry rd_ptr (combinational read of registered storage).
  - When count == 0 these outputs are don't-care; the bench must check them only when valid is high.
- Count update:
  - push & !pop: +1.
  - pop & !push: -1.
  - push & pop, or neither: unchanged.
- Full (count == DEPTH):
  - No push occurs, even if pop is asserted the same cycle.
  - The entry freed by a pop is reused at the earliest on the following cycle.
  - Fetch holds its instruction while stalled, so nothing is lost.
- Empty:
  - No pop occurs.
  - Push latency is 1 cycle: an instruction written in cycle N appears at decode in cycle N+1.
- Flush (highest priority):
  - Next cycle: rd_ptr=wr_ptr=0, count=0.
  - Any push or pop presented in the flush cycle is ignored.
  - decode_instr_valid may still be high during the flush cycle itself; decode must qualify with its own flush.
- Ordering: strict FIFO order. No reordering, no duplication, no drop except on flush.
- occupancy = count.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - Applies when count == 0 and fetch_instr_valid & !flush.
  - decode_instr_valid, decode_instr_data and decode_instr_pc are driven combinationally from the fetch inputs (0-cycle latency).
  - If !decode_stall that cycle, the instruction is consumed directly and not written (count stays 0).
  - If decode_stall, it is written as a normal push (count becomes 1).
- Not defined:
  - Outputs come from storage only; empty-queue latency is 1 cycle as above.

Test Plan:
1. Reset mid-stream: with count=3 (DEPTH=4), assert reset asynchronously between edges -> decode_instr_valid=0, occupancy=0, stall_fetch=0 immediately; first push after release lands at entry 0.
2. Fill/full: decode_stall=1; push PCs 0x100, 0x104, 0x108, 0x10C -> occupancy=4, stall_fetch=1; 5th instruction (0x110) not accepted. Release decode_stall -> pops in order 0x100..0x10C; 0x110 accepted the cycle after stall_fetch drops.
3. Simultaneous push/pop at count=2, continuous for 10 cycles -> occupancy stays 2; output PCs strictly increment by 4; pointers wrap past DEPTH-1 correctly.
4. Flush with push: count=3 plus fetch_instr_valid with PC 0x200 while flush=1 -> next cycle occupancy=0, valid=0. Next push of PC 0x400 appears at the head one cycle later (bypass off).
5. Empty pop attempt: count=0, decode_stall=0, no input for 5 cycles -> occupancy remains 0; no underflow (count never becomes all-ones).
6. Bypass (FETCH_QUEUE_BYPASS_EN): empty queue, push PC 0x300 with decode_stall=0 -> decode_instr_pc=0x300 and valid=1 in the same cycle; occupancy stays 0. Repeat with decode_stall=1 -> occupancy=1 next cycle, head PC 0x300.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// In-order fetch-to-decode instruction queue with full back-pressure and flush.
// Optional zero-latency empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.

`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module fetch_decode_queue #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = `INSTR_WIDTH,
    parameter int PC_W    = `PC_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     fetch_instr_valid,
    input  logic [INSTR_W-1:0]       fetch_instr_data,
    input  logic [PC_W-1:0]          fetch_instr_pc,
    output logic                     stall_fetch,
    input  logic                     decode_stall,
    output logic                     decode_instr_valid,
    output logic [INSTR_W-1:0]       decode_instr_data,
    output logic [PC_W-1:0]          decode_instr_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = INSTR_W + PC_W;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [EW-1:0] storage [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          stored_valid;
    logic          push;
    logic          pop;
    logic          write;
    logic          bypass_take;
    logic [EW-1:0] head_entry;

    // Full is a pure function of registered count, so fetch never sees a comb path.
    assign stall_fetch  = (count == FULL_COUNT);
    assign stored_valid = (count != '0);
    assign head_entry   = storage[rd_ptr];
    assign occupancy    = count;

    assign push = fetch_instr_valid & ~stall_fetch & ~flush;
    assign pop  = stored_valid & ~decode_stall & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_active;

    assign bypass_active = ~stored_valid & fetch_instr_valid & ~flush;
    assign bypass_take   = bypass_active & ~decode_stall;

    always_comb begin
        decode_instr_valid = stored_valid;
        decode_instr_data  = head_entry[EW-1:PC_W];
        decode_instr_pc    = head_entry[PC_W-1:0];
        if (bypass_active) begin
            decode_instr_valid = 1'b1;
            decode_instr_data  = fetch_instr_data;
            decode_instr_pc    = fetch_instr_pc;
        end
    end
`else
    assign bypass_take        = 1'b0;
    assign decode_instr_valid = stored_valid;
    assign decode_instr_data  = head_entry[EW-1:PC_W];
    assign decode_instr_pc    = head_entry[PC_W-1:0];
`endif

    // An instruction consumed straight off the bypass never occupies an entry.
    assign write = push & ~bypass_take;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (write && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !write) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage is data-only and deliberately left unreset.
    always_ff @(posedge clock) begin
        if (write) begin
            storage[wr_ptr] <= {fetch_instr_data, fetch_instr_pc};
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the instruction stream.

module tb_fetch_decode_queue;

    localparam int DEPTH = 4;
    localparam int IW    = 32;
    localparam int PW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clock = 1'b0;
    logic           reset;
    logic           flush;
    logic           fv;
    logic [IW-1:0]  fd;
    logic [PW-1:0]  fp;
    logic           ds;
    logic           stall_fetch;
    logic           decode_instr_valid;
    logic [IW-1:0]  decode_instr_data;
    logic [PW-1:0]  decode_instr_pc;
    logic [CW-1:0]  occupancy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [IW+PW-1:0] mq[$];

    int               cmp_n;
    bit               cmp_valid;
    logic [IW+PW-1:0] cmp_head;

    fetch_decode_queue #(
        .DEPTH  (DEPTH),
        .INSTR_W(IW),
        .PC_W   (PW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .fetch_instr_valid (fv),
        .fetch_instr_data  (fd),
        .fetch_instr_pc    (fp),
        .stall_fetch       (stall_fetch),
        .decode_stall      (ds),
        .decode_instr_valid(decode_instr_valid),
        .decode_instr_data (decode_instr_data),
        .decode_instr_pc   (decode_instr_pc),
        .occupancy         (occupancy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model of one rising edge: the queue is the list of instructions decode has yet to see.
    task automatic model_step();
        int n;
        bit do_push;
        bit do_pop;
        bit byp;
        n = mq.size();
        if (flush) begin
            mq.delete();
        end else begin
            do_push = fv && (n < DEPTH);
            do_pop  = (n > 0) && !ds;
            byp     = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            byp = (n == 0) && fv && !ds;
`endif
            if (byp) do_push = 1'b0;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({fd, fp});
        end
    endtask

    task automatic cycle(input bit v, input logic [PW-1:0] pc, input bit st, input bit fl);
        fv    = v;
        fp    = pc;
        fd    = $urandom;
        ds    = st;
        flush = fl;
        @(posedge clock);
        model_step();
        #1;
        fv    = 1'b0;
        flush = 1'b0;
    endtask

    always @(negedge clock) begin
        if (cmp_en && !reset) begin
            cmp_n     = mq.size();
            cmp_valid = (cmp_n != 0);
            cmp_head  = cmp_valid ? mq[0] : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
            if (cmp_n == 0 && fv && !flush) begin
                cmp_valid = 1'b1;
                cmp_head  = {fd, fp};
            end
`endif
            chk("occupancy", 64'(occupancy), 64'(cmp_n));
            chk("stall_fetch", 64'(stall_fetch), 64'(cmp_n == DEPTH));
            chk("decode_valid", 64'(decode_instr_valid), 64'(cmp_valid));
            if (cmp_valid) begin
                chk("decode_data", 64'(decode_instr_data), 64'(cmp_head[IW+PW-1:PW]));
                chk("decode_pc", 64'(decode_instr_pc), 64'(cmp_head[PW-1:0]));
            end
        end
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        fv    = 1'b0;
        fd    = '0;
        fp    = '0;
        ds    = 1'b0;
        #1;
        chk("reset_valid", 64'(decode_instr_valid), 64'd0);
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_stall", 64'(stall_fetch), 64'd0);
        @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1 cmp_en = 1'b1;

        // Asynchronous reset with three entries held.
        cycle(1, 32'h700, 1, 0);
        cycle(1, 32'h704, 1, 0);
        cycle(1, 32'h708, 1, 0);
        chk("pre_reset_occupancy", 64'(occupancy), 64'd3);
        cmp_en = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("async_reset_valid", 64'(decode_instr_valid), 64'd0);
        chk("async_reset_occupancy", 64'(occupancy), 64'd0);
        chk("async_reset_stall", 64'(stall_fetch), 64'd0);
        mq.delete();
        @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1 cmp_en = 1'b1;
        cycle(1, 32'h600, 1, 0);
        chk("post_reset_occupancy", 64'(occupancy), 64'd1);
        chk("post_reset_head_pc", 64'(decode_instr_pc), 64'h600);
        cycle(0, 32'h0, 0, 0);
        chk("drained_occupancy", 64'(occupancy), 64'd0);

        // Fill to full, refused fifth instruction, then in-order drain.
        cycle(1, 32'h100, 1, 0);
        cycle(1, 32'h104, 1, 0);
        cycle(1, 32'h108, 1, 0);
        cycle(1, 32'h10C, 1, 0);
        chk("full_occupancy", 64'(occupancy), 64'd4);
        chk("full_stall", 64'(stall_fetch), 64'd1);
        cycle(1, 32'h110, 1, 0);
        chk("full_refuse_occupancy", 64'(occupancy), 64'd4);
        chk("drain_head0", 64'(decode_instr_pc), 64'h100);
        cycle(1, 32'h110, 0, 0);
        chk("pop_at_full_occupancy", 64'(occupancy), 64'd3);
        chk("stall_dropped", 64'(stall_fetch), 64'd0);
        chk("drain_head1", 64'(decode_instr_pc), 64'h104);
        cycle(1, 32'h110, 0, 0);
        chk("push_after_full_occupancy", 64'(occupancy), 64'd3);
        chk("drain_head2", 64'(decode_instr_pc), 64'h108);
        cycle(0, 32'h0, 0, 0);
        chk("drain_head3", 64'(decode_instr_pc), 64'h10C);
        cycle(0, 32'h0, 0, 0);
        chk("drain_head4", 64'(decode_instr_pc), 64'h110);
        cycle(0, 32'h0, 0, 0);
        chk("drain_empty", 64'(occupancy), 64'd0);

        // Steady push+pop at count 2 across pointer wrap.
        cycle(1, 32'h500, 1, 0);
        cycle(1, 32'h504, 1, 0);
        for (int i = 0; i < 10; i++) begin
            chk("steady_head_pc", 64'(decode_instr_pc), 64'(32'h500 + 4 * i));
            cycle(1, 32'h508 + 32'(4 * i), 0, 0);
            chk("steady_occupancy", 64'(occupancy), 64'd2);
        end

        // Flush with a concurrent push.
        cycle(1, 32'h550, 1, 0);
        chk("preflush_occupancy", 64'(occupancy), 64'd3);
        cycle(1, 32'h200, 0, 1);
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(decode_instr_valid), 64'd0);
        cycle(1, 32'h400, 1, 0);
        chk("postflush_valid", 64'(decode_instr_valid), 64'd1);
        chk("postflush_head_pc", 64'(decode_instr_pc), 64'h400);

        // Pop attempts on an empty queue.
        cycle(0, 32'h0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 32'h0, 0, 0);
            chk("empty_occupancy", 64'(occupancy), 64'd0);
            chk("empty_valid", 64'(decode_instr_valid), 64'd0);
        end

`ifdef FETCH_QUEUE_BYPASS_EN
        fv = 1'b1; fp = 32'h300; fd = $urandom; ds = 1'b0; flush = 1'b0;
        #1;
        chk("bypass_valid", 64'(decode_instr_valid), 64'd1);
        chk("bypass_pc", 64'(decode_instr_pc), 64'h300);
        @(posedge clock);
        model_step();
        #1 fv = 1'b0;
        chk("bypass_consumed_occupancy", 64'(occupancy), 64'd0);
        fv = 1'b1; fp = 32'h300; fd = $urandom; ds = 1'b1;
        #1;
        chk("bypass_stalled_pc", 64'(decode_instr_pc), 64'h300);
        @(posedge clock);
        model_step();
        #1 fv = 1'b0;
        chk("bypass_stalled_occupancy", 64'(occupancy), 64'd1);
        chk("bypass_stalled_head_pc", 64'(decode_instr_pc), 64'h300);
        cycle(0, 32'h0, 0, 1);
`endif

        // Random traffic: balanced phase, then a decode-congested phase.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 59) == 0);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
